// File: rtl/roulette_pkg.sv
// Shared roulette constants: scan codes, bet opcodes, ledger state encoding.
package roulette_pkg;

  localparam int unsigned BET_W = 8;

  localparam logic [5:0] OPC_SPIN = 6'h3E;
  localparam logic [5:0] OPC_NONE = 6'h3F;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [0:0] LEDGER_OPEN   = 1'b0;
  localparam logic [0:0] LEDGER_LOCKED = 1'b1;

  // Slot layout: chip colour low bits above the opcode.
  function automatic logic [BET_W-1:0] pack_bet(logic [1:0] color, logic [5:0] opcode);
    return {color, opcode};
  endfunction

endpackage

// File: rtl/bet_ledger_if.sv
// Bet ledger bus: keyboard/Arduino inputs in, ledger contents and status out.
interface bet_ledger_if #(
  parameter int unsigned NUM_SLOTS = 12,
  parameter int unsigned CNT_W     = 4
);
  import roulette_pkg::*;

  logic                         rx_valid;
  logic [7:0]                   rx_byte;
  logic [5:0]                   key_opcode;
  logic [2:0]                   chip_color;
  logic                         round_done;
  logic [BET_W*NUM_SLOTS-1:0]   bet_flat;
  logic [CNT_W-1:0]             bet_count;
  logic                         spin_check;
  logic                         spin_pulse;
  logic                         ledger_full;
  logic                         overflow;

  modport master (
    output rx_valid, rx_byte, key_opcode, chip_color, round_done,
    input  bet_flat, bet_count, spin_check, spin_pulse, ledger_full, overflow
  );

  modport slave (
    input  rx_valid, rx_byte, key_opcode, chip_color, round_done,
    output bet_flat, bet_count, spin_check, spin_pulse, ledger_full, overflow
  );

endinterface

// File: rtl/scan_make_filter.sv
// PS/2 byte parser: drops break/extended sequences and typematic repeats so that
// one physical keypress produces a single make_valid strobe.
module scan_make_filter
  import roulette_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic [5:0] key_opcode,
  output logic       make_valid,
  output logic [5:0] make_opcode
);

  logic       break_pend_q, break_pend_d;
  logic       ext_pend_q, ext_pend_d;
  logic [7:0] last_make_q, last_make_d;

  assign make_opcode = key_opcode;

  // Classify the incoming byte against the pending prefix flags.
  always_comb begin
    break_pend_d = break_pend_q;
    ext_pend_d   = ext_pend_q;
    last_make_d  = last_make_q;
    make_valid   = 1'b0;
    if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        break_pend_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_pend_d = 1'b1;
      end else if (break_pend_q) begin
        // Key release: re-arm the key so the next press counts again.
        break_pend_d = 1'b0;
        ext_pend_d   = 1'b0;
        if (rx_byte == last_make_q) last_make_d = 8'h00;
      end else if (ext_pend_q) begin
        ext_pend_d = 1'b0;
      end else if (rx_byte != last_make_q) begin
        last_make_d = rx_byte;
        make_valid  = 1'b1;
      end
    end
  end

  // Parser state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
      last_make_q  <= 8'h00;
    end else begin
      break_pend_q <= break_pend_d;
      ext_pend_q   <= ext_pend_d;
      last_make_q  <= last_make_d;
    end
  end

endmodule

// File: rtl/bet_ledger.sv
// Bet ledger: stores filtered bets in order, locks on spin until round_done.
module bet_ledger
  import roulette_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 12,
  parameter int unsigned CNT_W     = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  bet_ledger_if.slave  bus
);

  logic                             make_valid;
  logic [5:0]                       make_opcode;
  logic [0:0]                       state_q, state_d;
  logic [NUM_SLOTS-1:0][BET_W-1:0]  slot_q, slot_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             overflow_q, overflow_d;
  logic                             pulse_q, pulse_d;
  logic                             full;

  scan_make_filter u_filter (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_valid    (bus.rx_valid),
    .rx_byte     (bus.rx_byte),
    .key_opcode  (bus.key_opcode),
    .make_valid  (make_valid),
    .make_opcode (make_opcode)
  );

  assign full            = (count_q == CNT_W'(NUM_SLOTS));
  assign bus.bet_flat    = slot_q;
  assign bus.bet_count   = count_q;
  assign bus.spin_check  = (state_q == LEDGER_LOCKED);
  assign bus.spin_pulse  = pulse_q;
  assign bus.ledger_full = full;
  assign bus.overflow    = overflow_q;

  // Ledger FSM: append bets while open, freeze while locked, clear on round_done.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pulse_d    = 1'b0;
    if (state_q == LEDGER_LOCKED) begin
      // round_done takes priority over any byte arriving in the same cycle.
      if (bus.round_done) begin
        state_d    = LEDGER_OPEN;
        slot_d     = '0;
        count_d    = '0;
        overflow_d = 1'b0;
      end
    end else if (make_valid) begin
      if (make_opcode == OPC_SPIN) begin
        if (count_q != '0) begin
          state_d = LEDGER_LOCKED;
          pulse_d = 1'b1;
        end
      end else if (make_opcode != OPC_NONE && bus.chip_color != 3'b000) begin
        if (!full) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (CNT_W'(i) == count_q) slot_d[i] = pack_bet(bus.chip_color[1:0], make_opcode);
          end
          count_d = count_q + 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // Ledger state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LEDGER_OPEN;
      slot_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pulse_q    <= pulse_d;
    end
  end

endmodule

// File: tb/tb_bet_ledger.sv
// Directed bench for bet_ledger with hand-computed expected slot contents.
module tb_bet_ledger;

  localparam int unsigned NUM_SLOTS = 12;
  localparam int unsigned CNT_W     = 4;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  bet_ledger_if #(.NUM_SLOTS(NUM_SLOTS), .CNT_W(CNT_W)) bus_if ();

  bet_ledger #(.NUM_SLOTS(NUM_SLOTS), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slot(input int i);
    return bus_if.bet_flat[8*i +: 8];
  endfunction

  // One byte strobe; returns #1 after the capturing edge.
  task automatic send(input logic [7:0] b, input logic [5:0] op);
    bus_if.rx_valid   = 1'b1;
    bus_if.rx_byte    = b;
    bus_if.key_opcode = op;
    @(posedge clock);
    #1;
    bus_if.rx_valid   = 1'b0;
  endtask

  task automatic press(input logic [7:0] code, input logic [5:0] op);
    send(code, op);
    send(8'hF0, 6'h3F);
    send(code, 6'h3F);
  endtask

  task automatic pulse_round_done();
    bus_if.round_done = 1'b1;
    @(posedge clock);
    #1;
    bus_if.round_done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    reset_n           = 1'b0;
    bus_if.rx_valid   = 1'b0;
    bus_if.rx_byte    = 8'h00;
    bus_if.key_opcode = 6'h3F;
    bus_if.chip_color = 3'b000;
    bus_if.round_done = 1'b0;
    #3;
    check_eq("reset_count", 32'(bus_if.bet_count), 32'd0);
    check_eq("reset_flags", {28'd0, bus_if.spin_check, bus_if.spin_pulse, bus_if.ledger_full,
                             bus_if.overflow}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single bet, release does not add a second entry.
    bus_if.chip_color = 3'b010;
    send(8'h16, 6'd17);
    check_eq("bet_slot0", 32'(slot(0)), 32'h91);
    check_eq("bet_count1", 32'(bus_if.bet_count), 32'd1);
    send(8'hF0, 6'h3F);
    send(8'h16, 6'h3F);
    check_eq("bet_release_count", 32'(bus_if.bet_count), 32'd1);

    // Typematic repeat: only the first make is stored.
    send(8'h16, 6'd17);
    send(8'h16, 6'd17);
    send(8'h16, 6'd17);
    send(8'hF0, 6'h3F);
    send(8'h16, 6'h3F);
    check_eq("repeat_count", 32'(bus_if.bet_count), 32'd2);
    check_eq("repeat_slot1", 32'(slot(1)), 32'h91);
    press(8'h16, 6'd17);
    check_eq("repress_count", 32'(bus_if.bet_count), 32'd3);
    check_eq("repress_slot2", 32'(slot(2)), 32'h91);

    // Asynchronous reset mid-stream with three bets stored.
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_count", 32'(bus_if.bet_count), 32'd0);
    check_eq("async_reset_slot0", 32'(slot(0)), 32'h00);
    check_eq("async_reset_check", 32'(bus_if.spin_check), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Filters: no chip, NONE opcode, extended make.
    bus_if.chip_color = 3'b000;
    press(8'h1C, 6'd5);
    check_eq("filter_nochip", 32'(bus_if.bet_count), 32'd0);
    bus_if.chip_color = 3'b001;
    press(8'h1B, 6'h3F);
    check_eq("filter_none", 32'(bus_if.bet_count), 32'd0);
    send(8'hE0, 6'h3F);
    send(8'h75, 6'd7);
    check_eq("filter_ext", 32'(bus_if.bet_count), 32'd0);
    send(8'hE0, 6'h3F);
    send(8'hF0, 6'h3F);
    send(8'h75, 6'h3F);
    press(8'h1D, 6'd4);
    check_eq("filter_after_count", 32'(bus_if.bet_count), 32'd1);
    check_eq("filter_after_slot0", 32'(slot(0)), 32'h44);

    // Fill the ledger and overflow it.
    do_reset();
    bus_if.chip_color = 3'b011;
    for (int i = 0; i < 13; i++) begin
      press(8'h40 + 8'(i), 6'(i + 1));
      if (i == 10) check_eq("full_not_yet", 32'(bus_if.ledger_full), 32'd0);
      if (i == 11) begin
        check_eq("full_at12", 32'(bus_if.ledger_full), 32'd1);
        check_eq("no_overflow_at12", 32'(bus_if.overflow), 32'd0);
      end
    end
    check_eq("full_count", 32'(bus_if.bet_count), 32'd12);
    check_eq("full_overflow", 32'(bus_if.overflow), 32'd1);
    check_eq("full_slot0", 32'(slot(0)), 32'hC1);
    check_eq("full_slot11", 32'(slot(11)), 32'hCC);
    press(8'h3A, 6'h3E);
    check_eq("full_spin_lock", 32'(bus_if.spin_check), 32'd1);
    pulse_round_done();
    check_eq("clear_overflow", 32'(bus_if.overflow), 32'd0);
    check_eq("clear_full", 32'(bus_if.ledger_full), 32'd0);
    check_eq("clear_count", 32'(bus_if.bet_count), 32'd0);

    // Spin lock, ignored bets, round_done, empty spin.
    bus_if.chip_color = 3'b100;
    press(8'h11, 6'd9);
    press(8'h12, 6'd10);
    check_eq("spin_slot0", 32'(slot(0)), 32'h09);
    check_eq("spin_slot1", 32'(slot(1)), 32'h0A);
    check_eq("round_done_open", 32'(bus_if.spin_check), 32'd0);
    send(8'h29, 6'h3E);
    check_eq("spin_pulse_hi", 32'(bus_if.spin_pulse), 32'd1);
    check_eq("spin_check_hi", 32'(bus_if.spin_check), 32'd1);
    send(8'hF0, 6'h3F);
    check_eq("spin_pulse_lo", 32'(bus_if.spin_pulse), 32'd0);
    send(8'h29, 6'h3F);
    press(8'h13, 6'd11);
    check_eq("locked_count", 32'(bus_if.bet_count), 32'd2);
    check_eq("locked_slot2", 32'(slot(2)), 32'h00);
    check_eq("locked_check", 32'(bus_if.spin_check), 32'd1);
    // round_done together with a fresh make: cleared, byte not stored.
    bus_if.round_done = 1'b1;
    send(8'h14, 6'd12);
    bus_if.round_done = 1'b0;
    check_eq("rd_count", 32'(bus_if.bet_count), 32'd0);
    check_eq("rd_check", 32'(bus_if.spin_check), 32'd0);
    check_eq("rd_slot0", 32'(slot(0)), 32'h00);
    send(8'h14, 6'd12);
    check_eq("rd_parser_repeat", 32'(bus_if.bet_count), 32'd0);
    send(8'hF0, 6'h3F);
    send(8'h14, 6'h3F);
    send(8'h29, 6'h3E);
    check_eq("empty_spin_pulse", 32'(bus_if.spin_pulse), 32'd0);
    check_eq("empty_spin_check", 32'(bus_if.spin_check), 32'd0);
    send(8'hF0, 6'h3F);
    send(8'h29, 6'h3F);
    press(8'h15, 6'd5);
    check_eq("reopen_count", 32'(bus_if.bet_count), 32'd1);
    check_eq("reopen_slot0", 32'(slot(0)), 32'h05);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
